// File: rtl/ysyx_25010030_sim_pkg.sv
// Shared definitions for the NPC commit-side simulation monitor: FSM encoding,
// the trap instruction encoding and the watchdog exit code.
package ysyx_25010030_sim_pkg;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_DONE  = 2'd2
    } sim_state_e;

    localparam logic [31:0] EBREAK_INST   = 32'h0010_0073;
    localparam logic [31:0] WDT_EXIT_CODE = 32'hDEAD_0001;

endpackage

// File: rtl/ysyx_25010030_sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping; synchronous clear.
module ysyx_25010030_sat_counter #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             en,
    input  logic             clr,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clock) begin
        if (reset || clr) begin
            q <= '0;
        end else if (en && (q != '1)) begin
            q <= q + WIDTH'(1);
        end
    end

endmodule

// File: rtl/ysyx_25010030_sim_monitor.sv
// Commit-side simulation monitor: ends the run on ebreak (or idle watchdog when
// SIM_MONITOR_WATCHDOG_EN is defined), drains, then holds sim_end and results.
module ysyx_25010030_sim_monitor
    import ysyx_25010030_sim_pkg::*;
#(
    parameter int unsigned XLEN      = 32,
    parameter int unsigned CNT_W     = 64,
    parameter int unsigned DRAIN_CYC = 4,
    parameter int unsigned WDT_CYC   = 100000
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             commit_valid,
    input  logic [XLEN-1:0]  commit_pc,
    input  logic [31:0]      commit_inst,
    input  logic [XLEN-1:0]  commit_a0,
    output logic             halt_req,
    output logic             sim_end,
    output logic             sim_good,
    output logic [XLEN-1:0]  exit_code,
    output logic [XLEN-1:0]  trap_pc,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] instr_cnt
);

    localparam int unsigned     DRAIN_W    = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;
    localparam logic [DRAIN_W-1:0] DRAIN_LAST = (DRAIN_CYC == 0) ? '0 : DRAIN_W'(DRAIN_CYC - 1);

    sim_state_e         state_q, state_d;
    logic [DRAIN_W-1:0] drain_cnt;
    logic [XLEN-1:0]    last_pc;
    logic               run_c, trap_c, instr_en_c, wdt_fire_c;

    always_ff @(posedge clock) begin
        if (reset) state_q <= ST_RUN;
        else       state_q <= state_d;
    end

    // A zero-length drain skips DRAIN and goes straight to DONE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN:   if (trap_c || wdt_fire_c) state_d = (DRAIN_CYC == 0) ? ST_DONE : ST_DRAIN;
            ST_DRAIN: if (drain_cnt == DRAIN_LAST) state_d = ST_DONE;
            ST_DONE:  state_d = ST_DONE;
            default:  state_d = ST_RUN;
        endcase
    end

    always_comb begin
        run_c      = (state_q == ST_RUN);
        instr_en_c = run_c && commit_valid;
        trap_c     = instr_en_c && (commit_inst == EBREAK_INST);
    end

    ysyx_25010030_sat_counter #(.WIDTH(CNT_W)) u_cycle_cnt (
        .clock (clock),
        .reset (reset),
        .en    (run_c),
        .clr   (1'b0),
        .q     (cycle_cnt)
    );

    ysyx_25010030_sat_counter #(.WIDTH(CNT_W)) u_instr_cnt (
        .clock (clock),
        .reset (reset),
        .en    (instr_en_c),
        .clr   (1'b0),
        .q     (instr_cnt)
    );

`ifdef SIM_MONITOR_WATCHDOG_EN
    logic [31:0] idle_cnt;

    ysyx_25010030_sat_counter #(.WIDTH(32)) u_idle_cnt (
        .clock (clock),
        .reset (reset),
        .en    (run_c && !commit_valid),
        .clr   (instr_en_c),
        .q     (idle_cnt)
    );

    always_ff @(posedge clock) begin
        if (reset)           last_pc <= '0;
        else if (instr_en_c) last_pc <= commit_pc;
    end

    // Fires on the edge where the idle count would reach WDT_CYC; any commit pre-empts it.
    assign wdt_fire_c = run_c && !commit_valid && (idle_cnt == 32'(WDT_CYC - 1));
`else
    logic unused_wdt;

    assign last_pc    = '0;
    assign wdt_fire_c = 1'b0;
    assign unused_wdt = ^32'(WDT_CYC);
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            halt_req  <= 1'b0;
            sim_end   <= 1'b0;
            sim_good  <= 1'b0;
            exit_code <= '0;
            trap_pc   <= '0;
            drain_cnt <= '0;
        end else begin
            if (trap_c) begin
                halt_req  <= 1'b1;
                sim_good  <= (commit_a0 == '0);
                exit_code <= commit_a0;
                trap_pc   <= commit_pc;
            end else if (wdt_fire_c) begin
                halt_req  <= 1'b1;
                sim_good  <= 1'b0;
                exit_code <= XLEN'(WDT_EXIT_CODE);
                trap_pc   <= last_pc;
            end
            sim_end   <= (state_q == ST_DONE);
            drain_cnt <= (state_q == ST_DRAIN) ? drain_cnt + DRAIN_W'(1) : '0;
        end
    end

endmodule

// File: tb/tb_ysyx_25010030_sim_monitor.sv
// Directed bench for the simulation monitor; a second CNT_W=4 instance covers saturation.
module tb_ysyx_25010030_sim_monitor;

    localparam logic [31:0] EBREAK = 32'h0010_0073;
    localparam logic [31:0] NOP    = 32'h0000_0013;

    logic        clock = 1'b0;
    logic        reset;
    logic        commit_valid;
    logic [31:0] commit_pc, commit_inst, commit_a0;

    logic        halt_req, sim_end, sim_good;
    logic [31:0] exit_code, trap_pc;
    logic [63:0] cycle_cnt, instr_cnt;

    logic        s_halt_req, s_sim_end, s_sim_good;
    logic [31:0] s_exit_code, s_trap_pc;
    logic [3:0]  s_cycle_cnt, s_instr_cnt;

    int n_vec = 0;
    int n_err = 0;

    always #5 clock = ~clock;

    ysyx_25010030_sim_monitor #(.XLEN(32), .CNT_W(64), .DRAIN_CYC(4), .WDT_CYC(50)) dut (
        .clock(clock), .reset(reset), .commit_valid(commit_valid), .commit_pc(commit_pc),
        .commit_inst(commit_inst), .commit_a0(commit_a0), .halt_req(halt_req), .sim_end(sim_end),
        .sim_good(sim_good), .exit_code(exit_code), .trap_pc(trap_pc),
        .cycle_cnt(cycle_cnt), .instr_cnt(instr_cnt)
    );

    ysyx_25010030_sim_monitor #(.XLEN(32), .CNT_W(4), .DRAIN_CYC(4), .WDT_CYC(50)) dut_small (
        .clock(clock), .reset(reset), .commit_valid(commit_valid), .commit_pc(commit_pc),
        .commit_inst(commit_inst), .commit_a0(commit_a0), .halt_req(s_halt_req), .sim_end(s_sim_end),
        .sim_good(s_sim_good), .exit_code(s_exit_code), .trap_pc(s_trap_pc),
        .cycle_cnt(s_cycle_cnt), .instr_cnt(s_instr_cnt)
    );

    // Inputs change at a negedge; return at the following negedge, one posedge later.
    task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] inst, input logic [31:0] a0);
        commit_valid = v;
        commit_pc    = pc;
        commit_inst  = inst;
        commit_a0    = a0;
        @(negedge clock);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        drive(1'b0, 32'h0, 32'h0, 32'h0);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_vec++; if (halt_req !== 1'b0) begin n_err++; $display("FAIL reset_halt got %b want 0", halt_req); end
        n_vec++; if (sim_end !== 1'b0) begin n_err++; $display("FAIL reset_sim_end got %b want 0", sim_end); end
        n_vec++; if (sim_good !== 1'b0) begin n_err++; $display("FAIL reset_sim_good got %b want 0", sim_good); end
        n_vec++; if (exit_code !== 32'h0) begin n_err++; $display("FAIL reset_exit got %h want 0", exit_code); end
        n_vec++; if (trap_pc !== 32'h0) begin n_err++; $display("FAIL reset_trap_pc got %h want 0", trap_pc); end
        n_vec++; if (cycle_cnt !== 64'd0) begin n_err++; $display("FAIL reset_cycle got %0d want 0", cycle_cnt); end
        n_vec++; if (instr_cnt !== 64'd0) begin n_err++; $display("FAIL reset_instr got %0d want 0", instr_cnt); end
    endtask

    task automatic test_good_trap();
        do_reset();
        for (int i = 0; i < 10; i++) drive(1'b1, 32'h8000_0000 + 32'(i * 4), NOP, 32'(i));
        drive(1'b1, 32'h8000_0028, EBREAK, 32'h0);
        n_vec++; if (instr_cnt !== 64'd11) begin n_err++; $display("FAIL good_instr got %0d want 11", instr_cnt); end
        n_vec++; if (cycle_cnt !== 64'd11) begin n_err++; $display("FAIL good_cycle got %0d want 11", cycle_cnt); end
        n_vec++; if (sim_good !== 1'b1) begin n_err++; $display("FAIL good_sim_good got %b want 1", sim_good); end
        n_vec++; if (exit_code !== 32'h0) begin n_err++; $display("FAIL good_exit got %h want 0", exit_code); end
        n_vec++; if (trap_pc !== 32'h8000_0028) begin n_err++; $display("FAIL good_trap_pc got %h want 80000028", trap_pc); end
        n_vec++; if (halt_req !== 1'b1) begin n_err++; $display("FAIL good_halt got %b want 1", halt_req); end
        for (int k = 1; k <= 6; k++) begin
            drive(1'b0, 32'h0, 32'h0, 32'h0);
            n_vec++; if (sim_end !== (k >= 5)) begin n_err++; $display("FAIL good_sim_end k=%0d got %b want %b", k, sim_end, (k >= 5)); end
        end
        n_vec++; if (cycle_cnt !== 64'd11) begin n_err++; $display("FAIL good_cycle_frozen got %0d want 11", cycle_cnt); end
    endtask

    task automatic test_bad_trap();
        do_reset();
        drive(1'b1, 32'h8000_0038, NOP, 32'h3);
        drive(1'b1, 32'h8000_003c, NOP, 32'h3);
        drive(1'b1, 32'h8000_0040, EBREAK, 32'h3);
        n_vec++; if (sim_good !== 1'b0) begin n_err++; $display("FAIL bad_sim_good got %b want 0", sim_good); end
        n_vec++; if (exit_code !== 32'h3) begin n_err++; $display("FAIL bad_exit got %h want 3", exit_code); end
        n_vec++; if (trap_pc !== 32'h8000_0040) begin n_err++; $display("FAIL bad_trap_pc got %h want 80000040", trap_pc); end
        for (int k = 1; k <= 5; k++) drive(1'b0, 32'h0, 32'h0, 32'h0);
        n_vec++; if (sim_end !== 1'b1) begin n_err++; $display("FAIL bad_sim_end got %b want 1", sim_end); end
    endtask

    task automatic test_commits_after_trap();
        do_reset();
        for (int i = 0; i < 3; i++) drive(1'b1, 32'h8000_0100 + 32'(i * 4), NOP, 32'h0);
        drive(1'b1, 32'h8000_010c, EBREAK, 32'h7);
        for (int k = 1; k <= 9; k++) begin
            drive(1'b1, 32'h9000_0000 + 32'(k * 4), (k == 3) ? EBREAK : NOP, 32'h9);
            if (k >= 5) begin
                n_vec++; if (sim_end !== 1'b1) begin n_err++; $display("FAIL post_sim_end k=%0d got %b want 1", k, sim_end); end
            end
        end
        n_vec++; if (instr_cnt !== 64'd4) begin n_err++; $display("FAIL post_instr got %0d want 4", instr_cnt); end
        n_vec++; if (exit_code !== 32'h7) begin n_err++; $display("FAIL post_exit got %h want 7", exit_code); end
        n_vec++; if (trap_pc !== 32'h8000_010c) begin n_err++; $display("FAIL post_trap_pc got %h want 8000010c", trap_pc); end
        n_vec++; if (halt_req !== 1'b1) begin n_err++; $display("FAIL post_halt got %b want 1", halt_req); end
    endtask

    task automatic test_reset_mid_drain();
        do_reset();
        drive(1'b1, 32'h8000_0000, NOP, 32'h0);
        drive(1'b1, 32'h8000_0004, NOP, 32'h0);
        drive(1'b1, 32'h8000_0008, EBREAK, 32'h0);
        drive(1'b0, 32'h0, 32'h0, 32'h0);
        reset = 1'b1;
        drive(1'b0, 32'h0, 32'h0, 32'h0);
        reset = 1'b0;
        n_vec++; if (halt_req !== 1'b0) begin n_err++; $display("FAIL rst_drain_halt got %b want 0", halt_req); end
        n_vec++; if (instr_cnt !== 64'd0) begin n_err++; $display("FAIL rst_drain_instr got %0d want 0", instr_cnt); end
        n_vec++; if (sim_good !== 1'b0) begin n_err++; $display("FAIL rst_drain_good got %b want 0", sim_good); end
        for (int k = 1; k <= 8; k++) begin
            drive(1'b0, 32'h0, 32'h0, 32'h0);
            n_vec++; if (sim_end !== 1'b0) begin n_err++; $display("FAIL rst_drain_sim_end k=%0d got %b want 0", k, sim_end); end
        end
        for (int i = 0; i < 3; i++) drive(1'b1, 32'h8000_0200 + 32'(i * 4), NOP, 32'h0);
        n_vec++; if (instr_cnt !== 64'd3) begin n_err++; $display("FAIL rst_drain_instr2 got %0d want 3", instr_cnt); end
        n_vec++; if (cycle_cnt !== 64'd11) begin n_err++; $display("FAIL rst_drain_cycle got %0d want 11", cycle_cnt); end
    endtask

    task automatic test_saturation();
        do_reset();
        for (int i = 1; i <= 20; i++) begin
            drive(1'b1, 32'h8000_0000 + 32'(i * 4), NOP, 32'h0);
            if (i == 14) begin
                n_vec++; if (s_instr_cnt !== 4'hE) begin n_err++; $display("FAIL sat_instr14 got %h want e", s_instr_cnt); end
            end
        end
        n_vec++; if (s_instr_cnt !== 4'hF) begin n_err++; $display("FAIL sat_instr got %h want f", s_instr_cnt); end
        n_vec++; if (s_cycle_cnt !== 4'hF) begin n_err++; $display("FAIL sat_cycle got %h want f", s_cycle_cnt); end
        n_vec++; if (instr_cnt !== 64'd20) begin n_err++; $display("FAIL wide_instr got %0d want 20", instr_cnt); end
    endtask

`ifdef SIM_MONITOR_WATCHDOG_EN
    task automatic test_watchdog();
        do_reset();
        for (int k = 1; k <= 56; k++) begin
            drive(1'b0, 32'h0, 32'h0, 32'h0);
            if (k == 49) begin
                n_vec++; if (halt_req !== 1'b0) begin n_err++; $display("FAIL wdt_halt49 got %b want 0", halt_req); end
            end
            if (k == 50) begin
                n_vec++; if (halt_req !== 1'b1) begin n_err++; $display("FAIL wdt_halt50 got %b want 1", halt_req); end
                n_vec++; if (exit_code !== 32'hDEAD_0001) begin n_err++; $display("FAIL wdt_exit got %h want dead0001", exit_code); end
                n_vec++; if (sim_good !== 1'b0) begin n_err++; $display("FAIL wdt_good got %b want 0", sim_good); end
            end
            n_vec++; if (sim_end !== (k >= 55)) begin n_err++; $display("FAIL wdt_sim_end k=%0d got %b want %b", k, sim_end, (k >= 55)); end
        end
        do_reset();
        drive(1'b1, 32'h8000_0100, NOP, 32'h0);
        for (int k = 2; k <= 51; k++) begin
            drive(1'b0, 32'h0, 32'h0, 32'h0);
            if (k == 50) begin
                n_vec++; if (halt_req !== 1'b0) begin n_err++; $display("FAIL wdt2_halt50 got %b want 0", halt_req); end
            end
        end
        n_vec++; if (halt_req !== 1'b1) begin n_err++; $display("FAIL wdt2_halt51 got %b want 1", halt_req); end
        n_vec++; if (trap_pc !== 32'h8000_0100) begin n_err++; $display("FAIL wdt2_trap_pc got %h want 80000100", trap_pc); end
        do_reset();
        for (int k = 1; k <= 49; k++) drive(1'b0, 32'h0, 32'h0, 32'h0);
        drive(1'b1, 32'h8000_0200, EBREAK, 32'h5);
        n_vec++; if (exit_code !== 32'h5) begin n_err++; $display("FAIL wdt3_exit got %h want 5", exit_code); end
        n_vec++; if (trap_pc !== 32'h8000_0200) begin n_err++; $display("FAIL wdt3_trap_pc got %h want 80000200", trap_pc); end
        n_vec++; if (cycle_cnt !== 64'd50) begin n_err++; $display("FAIL wdt3_cycle got %0d want 50", cycle_cnt); end
    endtask
`else
    task automatic test_watchdog();
        do_reset();
        for (int k = 1; k <= 200; k++) drive(1'b0, 32'h0, 32'h0, 32'h0);
        n_vec++; if (halt_req !== 1'b0) begin n_err++; $display("FAIL nowdt_halt got %b want 0", halt_req); end
        n_vec++; if (sim_end !== 1'b0) begin n_err++; $display("FAIL nowdt_sim_end got %b want 0", sim_end); end
        n_vec++; if (cycle_cnt !== 64'd200) begin n_err++; $display("FAIL nowdt_cycle got %0d want 200", cycle_cnt); end
    endtask
`endif

    initial begin
        reset        = 1'b1;
        commit_valid = 1'b0;
        commit_pc    = '0;
        commit_inst  = '0;
        commit_a0    = '0;
        @(negedge clock);
        test_reset();
        test_good_trap();
        test_bad_trap();
        test_commits_after_trap();
        test_reset_mid_drain();
        test_saturation();
        test_watchdog();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
